// File: rtl/xf_pkg.sv
// Shared XF package: arbiter state encoding and matrix-memory geometry constants.
package xf_pkg;

  typedef enum logic [1:0] {
    XF_ARB_IDLE  = 2'd0,
    XF_ARB_ISSUE = 2'd1,
    XF_ARB_WAIT  = 2'd2,
    XF_ARB_HOLD  = 2'd3
  } xf_arb_state_t;

  localparam int XF_ROW_W  = 128;
  localparam int XF_ADDR_W = 6;

  // Width of an index into n clients; never narrower than one bit.
  function automatic int xf_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xf_posmat_arbiter_chk.sv
// Protocol checker for xf_posmat_arbiter: parameter ranges, memory strobe overlap,
// grant one-hotness and data-valid ownership.
module xf_posmat_arbiter_chk #(
  parameter int NUM_REQ     = 4,
  parameter int BURST_BEATS = 3,
  parameter int TIMEOUT     = 15
) (
  input logic               clk,
  input logic               reset,
  input logic               mem_enable,
  input logic               mem_valid,
  input logic [NUM_REQ-1:0] grant,
  input logic [NUM_REQ-1:0] req_valid
);

  a_params: assert property (@(posedge clk) disable iff (reset)
    (NUM_REQ >= 2) && (NUM_REQ <= 8) && (BURST_BEATS >= 1) && (BURST_BEATS <= 7) && (TIMEOUT >= 1));

  // Memory may never answer in the same cycle as the read strobe.
  a_no_same_cycle: assert property (@(posedge clk) disable iff (reset)
    !(mem_enable && mem_valid));

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));

  a_valid_owner: assert property (@(posedge clk) disable iff (reset)
    (req_valid & ~grant) == '0);

endmodule

// File: rtl/xf_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
// Shared by the XF position-matrix and command arbiters.
module xf_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = PW'(j);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/xf_posmat_arbiter.sv
// Round-robin arbiter sharing the XF position-matrix memory read port, with burst hold.
// Optional watchdog enabled by defining XF_POSMAT_ARB_TIMEOUT_EN.
module xf_posmat_arbiter
  import xf_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = XF_ADDR_W,
  parameter int DATA_W      = XF_ROW_W,
  parameter int BURST_BEATS = 3,
  parameter int TIMEOUT     = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_enable,
  output logic [DATA_W-1:0]         req_data,
  output logic [NUM_REQ-1:0]        req_valid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_enable,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      mem_valid,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int PW = xf_idx_w(NUM_REQ);
  localparam int BW = 3;

  xf_arb_state_t      state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      gidx;
  logic [BW-1:0]      beat_cnt;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  pick_addr;
  logic [ADDR_W-1:0]  grant_addr;
  logic [PW-1:0]      next_ptr;
  logic               timed_out;

  xf_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req    (req_enable),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign pick_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
  assign grant_addr = req_addr[gidx*ADDR_W +: ADDR_W];
  assign next_ptr   = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;

`ifdef XF_POSMAT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;
  logic          timeout_flag;

  assign timed_out   = (state == XF_ARB_WAIT) && !mem_valid && (wd_cnt == TW'(TIMEOUT - 1));
  assign timeout_err = timeout_flag;

  // Watchdog counts cycles spent in WAIT; the error flag is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      wd_cnt <= (state == XF_ARB_WAIT) ? wd_cnt + 1'b1 : '0;
      if (timed_out) begin
        timeout_flag <= 1'b1;
      end else begin
        timeout_flag <= timeout_flag;
      end
    end
  end
`else
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= XF_ARB_IDLE;
      rr_ptr     <= '0;
      gidx       <= '0;
      beat_cnt   <= '0;
      grant      <= '0;
      req_data   <= '0;
      req_valid  <= '0;
      mem_addr   <= '0;
      mem_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      req_valid <= '0;
      case (state)
        XF_ARB_IDLE: begin
          if (pick_any) begin
            grant      <= pick_onehot;
            gidx       <= pick_idx;
            mem_addr   <= pick_addr;
            mem_enable <= 1'b1;
            beat_cnt   <= BW'(1);
            busy       <= 1'b1;
            state      <= XF_ARB_ISSUE;
          end else begin
            state <= XF_ARB_IDLE;
          end
        end
        XF_ARB_ISSUE: begin
          mem_enable <= 1'b0;
          state      <= XF_ARB_WAIT;
        end
        XF_ARB_WAIT: begin
          if (mem_valid) begin
            req_data  <= mem_data;
            req_valid <= grant;
            state     <= XF_ARB_HOLD;
          end else if (timed_out) begin
            req_data  <= '0;
            req_valid <= grant;
            state     <= XF_ARB_HOLD;
          end else begin
            state <= XF_ARB_WAIT;
          end
        end
        XF_ARB_HOLD: begin
          // Keep the grant for the next row of a multi-row matrix load.
          if (req_enable[gidx] && (beat_cnt < BW'(BURST_BEATS))) begin
            mem_addr   <= grant_addr;
            mem_enable <= 1'b1;
            beat_cnt   <= beat_cnt + 1'b1;
            state      <= XF_ARB_ISSUE;
          end else begin
            grant    <= '0;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
            busy     <= 1'b0;
            state    <= XF_ARB_IDLE;
          end
        end
        default: begin
          grant      <= '0;
          mem_enable <= 1'b0;
          busy       <= 1'b0;
          state      <= XF_ARB_IDLE;
        end
      endcase
    end
  end

  xf_posmat_arbiter_chk #(
    .NUM_REQ     (NUM_REQ),
    .BURST_BEATS (BURST_BEATS),
    .TIMEOUT     (TIMEOUT)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .mem_enable (mem_enable),
    .mem_valid  (mem_valid),
    .grant      (grant),
    .req_valid  (req_valid)
  );

endmodule

// File: tb/tb_xf_posmat_arbiter.sv
// Scoreboard bench for xf_posmat_arbiter: client and memory models, directed scenarios,
// monitor comparing every req_valid pulse against hand-ordered expectations.
module tb_xf_posmat_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 128;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_enable;
  logic [DATA_W-1:0]         req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_enable;
  logic [DATA_W-1:0]         mem_data;
  logic                      mem_valid;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      timeout_err;

  always #5 clk = ~clk;

  xf_posmat_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_BEATS(3), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .req_addr(req_addr), .req_enable(req_enable),
    .req_data(req_data), .req_valid(req_valid), .mem_addr(mem_addr), .mem_enable(mem_enable),
    .mem_data(mem_data), .mem_valid(mem_valid), .grant(grant), .busy(busy),
    .timeout_err(timeout_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct { int idx; logic [DATA_W-1:0] data; } exp_t;
  typedef struct { int due; logic [ADDR_W-1:0] addr; } mreq_t;

  exp_t              sb[$];
  mreq_t             mq[$];
  logic [ADDR_W-1:0] cq[NUM_REQ][$];
  int                cyc      = 0;
  int                mem_lat  = 2;
  bit                mem_mute = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] row(input logic [ADDR_W-1:0] a);
    return {26'h0, a, 26'h1555555, a, 26'h2AAAAAA, a, 26'h3000000, a};
  endfunction

  function automatic bit clients_pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (cq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic expect_read(input int idx, input logic [ADDR_W-1:0] a, input bit zero);
    exp_t e;
    e.idx  = idx;
    e.data = zero ? '0 : row(a);
    sb.push_back(e);
  endtask

  task automatic drive_clients();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_enable[i] = (cq[i].size() != 0);
      req_addr[i*ADDR_W +: ADDR_W] = (cq[i].size() != 0) ? cq[i][0] : '0;
    end
  endtask

  // Clients hold enable while they have reads left and drop it in the cycle of their last req_valid.
  initial begin
    req_enable = '0;
    req_addr   = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && cq[i].size() != 0) void'(cq[i].pop_front());
      drive_clients();
      @(negedge clk); #1;
      drive_clients();
    end
  end

  // Memory answers each strobe mem_lat cycles later with a pattern derived from the address.
  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (mem_enable && !mem_mute) mq.push_back('{cyc + mem_lat, mem_addr});
      if (mq.size() != 0 && mq[0].due == cyc) begin
        mem_valid = 1'b1;
        mem_data  = row(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        mem_valid = 1'b0;
        mem_data  = '0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (req_valid !== '0) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req_valid: got %b expected none", req_valid);
        end else begin
          e = sb.pop_front();
          check("req_valid_owner", DATA_W'(req_valid), DATA_W'(1) << e.idx);
          check("req_data", req_data, e.data);
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy || clients_pending()) && n < 300) begin
      @(posedge clk); #3;
      n++;
    end
    check(name, DATA_W'(n < 300), DATA_W'(1));
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_req_valid"}, DATA_W'(req_valid), '0);
    check({tag, "_req_data"}, req_data, '0);
    check({tag, "_mem_addr"}, DATA_W'(mem_addr), '0);
    check({tag, "_mem_enable"}, DATA_W'(mem_enable), '0);
    check({tag, "_grant"}, DATA_W'(grant), '0);
    check({tag, "_busy"}, DATA_W'(busy), '0);
    check({tag, "_timeout_err"}, DATA_W'(timeout_err), '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) cq[i].delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single client read with memory latency 2.
    mem_lat = 2;
    expect_read(0, 6'h05, 1'b0);
    cq[0].push_back(6'h05);
    @(posedge clk); #2;
    check("t1_mem_enable_c1", DATA_W'(mem_enable), DATA_W'(1));
    check("t1_mem_addr", DATA_W'(mem_addr), DATA_W'(6'h05));
    check("t1_grant", DATA_W'(grant), DATA_W'(4'b0001));
    check("t1_busy", DATA_W'(busy), DATA_W'(1));
    n = 1;
    while (req_valid == '0 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check("t1_req_valid_cycle", DATA_W'(n), DATA_W'(4));
    wait_done("t1_done");
    check("t1_grant_released", DATA_W'(grant), '0);
    check("t1_busy_released", DATA_W'(busy), '0);

    // Clients 0 and 2 together: 3-beat burst for 0, then 2.
    do_reset();
    mem_lat = 1;
    expect_read(0, 6'h10, 1'b0);
    expect_read(0, 6'h11, 1'b0);
    expect_read(0, 6'h12, 1'b0);
    expect_read(2, 6'h30, 1'b0);
    expect_read(2, 6'h31, 1'b0);
    cq[0].push_back(6'h10); cq[0].push_back(6'h11); cq[0].push_back(6'h12);
    cq[2].push_back(6'h30); cq[2].push_back(6'h31);
    wait_done("t2_done");

    // Client 1 wants 5 reads; burst capped at 3 and client 3 goes in between.
    do_reset();
    mem_lat = 3;
    expect_read(1, 6'h08, 1'b0);
    expect_read(1, 6'h09, 1'b0);
    expect_read(1, 6'h0A, 1'b0);
    expect_read(3, 6'h3F, 1'b0);
    expect_read(1, 6'h0B, 1'b0);
    expect_read(1, 6'h0C, 1'b0);
    for (int k = 0; k < 5; k++) cq[1].push_back(ADDR_W'(6'h08 + k));
    cq[3].push_back(6'h3F);
    wait_done("t3_done");

    // All four request 4 rows: 3-beat bursts 0,1,2,3 then single beats 0,1,2,3.
    do_reset();
    mem_lat = 2;
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 3; k++) expect_read(i, ADDR_W'(6'h20 + i * 4 + k), 1'b0);
    for (int i = 0; i < NUM_REQ; i++) expect_read(i, ADDR_W'(6'h20 + i * 4 + 3), 1'b0);
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 4; k++) cq[i].push_back(ADDR_W'(6'h20 + i * 4 + k));
    wait_done("t4_done");
    check("t4_timeout_err", DATA_W'(timeout_err), '0);

    // Reset during WAIT drops the in-flight read and restarts the rotation at client 0.
    do_reset();
    mem_lat = 1;
    expect_read(2, 6'h21, 1'b0);
    cq[2].push_back(6'h21);
    wait_done("t5_pre_done");
    mem_lat = 6;
    cq[3].push_back(6'h33);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) cq[i].delete();
    #1;
    check_cleared("t5_mid_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_late_resp_seen", DATA_W'(mq.size() == 0), DATA_W'(1));
    check("t5_idle_after_late", DATA_W'(busy), '0);
    mem_lat = 2;
    expect_read(1, 6'h01, 1'b0);
    expect_read(3, 6'h03, 1'b0);
    cq[1].push_back(6'h01);
    cq[3].push_back(6'h03);
    wait_done("t5_done");

`ifdef XF_POSMAT_ARB_TIMEOUT_EN
    // Memory never answers: zero data after 15 WAIT cycles, sticky error.
    do_reset();
    mem_mute = 1'b1;
    expect_read(0, 6'h07, 1'b1);
    cq[0].push_back(6'h07);
    repeat (10) @(negedge clk);
    check("t6_err_before", DATA_W'(timeout_err), '0);
    wait_done("t6_done");
    check("t6_err_set", DATA_W'(timeout_err), DATA_W'(1));
    repeat (5) @(negedge clk);
    check("t6_err_sticky", DATA_W'(timeout_err), DATA_W'(1));
    mem_mute = 1'b0;
    do_reset();
    check("t6_err_cleared", DATA_W'(timeout_err), '0);
`endif

    repeat (4) @(negedge clk);
    check("final_scoreboard_empty", DATA_W'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
